// File: rtl/priority_encoder.sv
// ============================================================================
// Module   : priority_encoder
// Brief    : Registered N-to-$clog2(N) priority encoder. The most significant
//            set bit of A wins. The index and a valid flag are registered
//            on clk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_encoder #(
  parameter  int N = 8,
  localparam int W = (N < 2) ? 1 : $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  output logic [W-1:0] O,
  output logic         valid
);

  logic [W-1:0] idx_d;
  logic         valid_d;
  logic [W-1:0] idx_q;
  logic         valid_q;

  // Ascending scan. Each later (higher) set bit overwrites the index, so the
  // MSB wins. An all-zero A leaves index 0 with valid low.
  always_comb begin
    idx_d   = '0;
    valid_d = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (A[i]) begin
        idx_d   = W'(i);
        valid_d = 1'b1;
      end
    end
  end

  // Sample the encode result every cycle. Reset clears both outputs
  // immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign O     = idx_q;
  assign valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_priority_encoder.sv
// ============================================================================
// Module   : tb_priority_encoder
// Brief    : Directed, table-driven bench for priority_encoder, with instances
//            at N = 8 and N = 5.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_priority_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] a8;
  logic [2:0] o8;
  logic       v8;
  logic [4:0] a5;
  logic [2:0] o5;
  logic       v5;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [2:0] o;
    logic       v;
  } vec8_t;

  typedef struct {
    logic [4:0] a;
    logic [2:0] o;
    logic       v;
  } vec5_t;

  vec8_t t8[14];
  vec5_t t5[6];

  priority_encoder #(.N(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a8),
    .O     (o8),
    .valid (v8)
  );

  priority_encoder #(.N(5)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a5),
    .O     (o5),
    .valid (v5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] o_act, input logic v_act,
                       input logic [2:0] o_exp, input logic v_exp);
    checks++;
    if (o_act !== o_exp || v_act !== v_exp) begin
      errors++;
      $display("FAIL %s: got O=%0d valid=%0b, expected O=%0d valid=%0b",
               name, o_act, v_act, o_exp, v_exp);
    end
  endtask

  // Drive the inputs at the falling edge, then look at the outputs just after
  // the next rising edge.
  task automatic step8(input logic [7:0] a);
    @(negedge clk);
    a8 = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Expected values worked out by hand.
    t8[0]  = '{8'b0000_1000, 3'd3, 1'b1};
    t8[1]  = '{8'b0000_0010, 3'd1, 1'b1};
    t8[2]  = '{8'b1000_0000, 3'd7, 1'b1};
    t8[3]  = '{8'b0000_0001, 3'd0, 1'b1};
    t8[4]  = '{8'b0000_0110, 3'd2, 1'b1};
    t8[5]  = '{8'b1111_1111, 3'd7, 1'b1};
    t8[6]  = '{8'b0101_0001, 3'd6, 1'b1};
    t8[7]  = '{8'b0000_0000, 3'd0, 1'b0};
    t8[8]  = '{8'b0000_0001, 3'd0, 1'b1};
    t8[9]  = '{8'b0010_0100, 3'd5, 1'b1};
    t8[10] = '{8'b0001_0000, 3'd4, 1'b1};
    t8[11] = '{8'b0100_0000, 3'd6, 1'b1};
    t8[12] = '{8'b0000_0000, 3'd0, 1'b0};
    t8[13] = '{8'b0001_1111, 3'd4, 1'b1};

    t5[0] = '{5'b10010, 3'd4, 1'b1};
    t5[1] = '{5'b00001, 3'd0, 1'b1};
    t5[2] = '{5'b01100, 3'd3, 1'b1};
    t5[3] = '{5'b00000, 3'd0, 1'b0};
    t5[4] = '{5'b11111, 3'd4, 1'b1};
    t5[5] = '{5'b00110, 3'd2, 1'b1};

    // Assert reset asynchronously, away from any clock edge, with A all ones.
    rst_n = 1'b1;
    a8    = 8'hFF;
    a5    = 5'h1F;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", o8, v8, 3'd0, 1'b0);
    check("async_reset_n5", o5, v5, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", o8, v8, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", o8, v8, 3'd7, 1'b1);

    // Main table. Its rows are applied on consecutive cycles.
    for (int i = 0; i < 14; i++) begin
      step8(t8[i].a);
      check($sformatf("vec8[%0d]", i), o8, v8, t8[i].o, t8[i].v);
    end

    // Back-to-back sequence, one new A per cycle. Each result lags its A by
    // exactly one edge.
    begin
      logic [7:0] seq_a[6];
      logic [2:0] seq_o[6];
      logic       seq_v[6];
      seq_a = '{8'h08, 8'h02, 8'h06, 8'h00, 8'h80, 8'h01};
      seq_o = '{3'd3, 3'd1, 3'd2, 3'd0, 3'd7, 3'd0};
      seq_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
        step8(seq_a[i]);
        check($sformatf("b2b[%0d]", i), o8, v8, seq_o[i], seq_v[i]);
      end
    end

    // A glitch on A between edges must not disturb the registered outputs.
    step8(8'h08);
    check("glitch_pre", o8, v8, 3'd3, 1'b1);
    #2 a8 = 8'hFF;
    #1 a8 = 8'h00;
    #1 a8 = 8'h02;
    #1;
    check("glitch_mid", o8, v8, 3'd3, 1'b1);
    @(posedge clk);
    #1;
    check("glitch_post", o8, v8, 3'd1, 1'b1);

    // Instance with a non-power-of-two width (N = 5).
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a5 = t5[i].a;
      @(posedge clk);
      #1;
      check($sformatf("vec5[%0d]", i), o5, v5, t5[i].o, t5[i].v);
    end

    // Assert reset mid-stream while valid is high. Both outputs must clear
    // at once and stay cleared until reset is released.
    step8(8'h40);
    a5 = 5'b10010;
    @(posedge clk);
    #1;
    check("pre_midreset", o8, v8, 3'd6, 1'b1);
    check("pre_midreset_n5", o5, v5, 3'd4, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_async", o8, v8, 3'd0, 1'b0);
    check("midreset_async_n5", o5, v5, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    check("midreset_hold", o8, v8, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset_released_preedge", o8, v8, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    check("midreset_first_sample", o8, v8, 3'd6, 1'b1);
    check("midreset_first_sample_n5", o5, v5, 3'd4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
